// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples a scanned 7-segment bus (segment pattern plus
// one-hot digit select), waits for a run of identical samples, then decodes
// the pattern back to its 3-bit code and stores it per digit position.
module seg_scan_capture #(
   parameter int unsigned DIGITS        = 8,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [8:0]            seg_led,
   input  logic [DIGITS-1:0]     dig_sel,
   input  logic                  clr,
   output logic [3*DIGITS-1:0]   code_out,
   output logic [DIGITS-1:0]     valid,
   output logic [DIGITS-1:0]     err,
   output logic                  frame_done
);

   localparam int unsigned SW        = DIGITS + 7;
   localparam logic [3:0]  STABLE    = 4'(STABLE_CYCLES);
   localparam logic [3:0]  STABLE_M1 = 4'(STABLE_CYCLES - 1);

   // Sample is {dig_sel, seg_led[6:0]}; prev holds the sample one edge older
   logic [SW-1:0]         samp_q, samp_d;
   logic [SW-1:0]         prev_q, prev_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [3*DIGITS-1:0]   code_q, code_d;
   logic [DIGITS-1:0]     valid_q, valid_d;
   logic [DIGITS-1:0]     err_q, err_d;
   logic                  frame_q, frame_d;
   logic                  fired_q, fired_d;

   logic                  wipe;
   logic                  sel_onehot;
   logic                  same;
   logic                  commit;
   logic [3:0]            dec;

   // Maps a segment pattern to {recognised, code}
   function automatic logic [3:0] decode(input logic [6:0] s);
      logic [3:0] r;
      case (s)
         7'h3f:   r = 4'b1_000;
         7'h06:   r = 4'b1_001;
         7'h5b:   r = 4'b1_010;
         7'h4f:   r = 4'b1_011;
         7'h66:   r = 4'b1_100;
         7'h6d:   r = 4'b1_101;
         7'h7d:   r = 4'b1_110;
         7'h07:   r = 4'b1_111;
         default: r = 4'b0_000;
      endcase
      return r;
   endfunction

   assign wipe       = rst | clr;
   assign sel_onehot = $onehot(samp_q[SW-1:7]);
   assign same       = (samp_q == prev_q);
   assign dec        = decode(samp_q[6:0]);

   // The counter judges the registered sample against the one before it, so
   // the commit edge is one edge after the last required input sample.
   assign commit     = !wipe && sel_onehot && same && (cnt_q == STABLE_M1);

   // Input sample pipeline (seg_led[8:7] dropped)
   always_comb begin
      samp_d = {dig_sel, seg_led[6:0]};
      prev_d = samp_q;
      if (wipe) begin
         samp_d = '0;
         prev_d = '0;
      end
   end

   // Stability counter, saturating at STABLE_CYCLES
   always_comb begin
      cnt_d = cnt_q;
      if (wipe || !sel_onehot) begin
         cnt_d = '0;
      end else if (same) begin
         cnt_d = (cnt_q >= STABLE) ? STABLE : cnt_q + 4'd1;
      end else begin
         cnt_d = 4'd1;
      end
   end

   // Per-digit capture on commit, and one-shot frame-complete pulse
   always_comb begin
      code_d  = code_q;
      valid_d = valid_q;
      err_d   = err_q;
      frame_d = (&valid_q) && !fired_q;
      fired_d = fired_q | (&valid_q);
      if (commit) begin
         for (int unsigned i = 0; i < DIGITS; i++) begin
            if (samp_q[7+i]) begin
               if (dec[3]) begin
                  code_d[3*i +: 3] = dec[2:0];
                  valid_d[i]       = 1'b1;
                  err_d[i]         = 1'b0;
               end else begin
                  err_d[i]         = 1'b1;
               end
            end
         end
      end
      if (wipe) begin
         code_d  = '0;
         valid_d = '0;
         err_d   = '0;
         frame_d = 1'b0;
         fired_d = 1'b0;
      end
   end

   // State registers (clearing is folded into the _d logic above)
   always_ff @(posedge clk) begin
      samp_q  <= samp_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      frame_q <= frame_d;
      fired_q <= fired_d;
   end

   assign code_out   = code_q;
   assign valid      = valid_q;
   assign err        = err_q;
   assign frame_done = frame_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture (DIGITS=8, STABLE_CYCLES=4).
module tb_seg_scan_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic [8:0]  seg_led;
   logic [7:0]  dig_sel;
   logic        clr;
   logic [23:0] code_out;
   logic [7:0]  valid;
   logic [7:0]  err;
   logic        frame_done;

   int total = 0;
   int bad   = 0;
   int fd_count = 0;

   logic [6:0] pat [8] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07};

   seg_scan_capture #(.DIGITS(8), .STABLE_CYCLES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .seg_led    (seg_led),
      .dig_sel    (dig_sel),
      .clr        (clr),
      .code_out   (code_out),
      .valid      (valid),
      .err        (err),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_done) fd_count++;

   initial begin
      #2_000_000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic [7:0] d, input logic [6:0] p, input int n);
      for (int k = 0; k < n; k++) begin
         dig_sel = d;
         seg_led = {2'($urandom_range(3)), p};
         tick();
      end
   endtask

   task automatic idle();
      dig_sel = 8'h00;
      seg_led = 9'h000;
      tick();
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0;
      seg_led = 9'($urandom); dig_sel = 8'($urandom);
      tick();
      seg_led = 9'($urandom); dig_sel = 8'($urandom);
      tick();
      check("rst_code", 64'(code_out), 64'h0);
      check("rst_valid", 64'(valid), 64'h0);
      check("rst_err", 64'(err), 64'h0);
      check("rst_frame", 64'(frame_done), 64'h0);
      rst = 1'b0;
      idle();

      // single capture on digit 2
      hold(8'h04, 7'h5b, 4);
      check("single_latency", 64'(valid), 64'h0);
      hold(8'h04, 7'h5b, 1);
      check("single_code", 64'(code_out), 64'h000080);
      check("single_valid", 64'(valid), 64'h04);
      check("single_err", 64'(err), 64'h0);
      hold(8'h04, 7'h5b, 20);
      check("single_hold_code", 64'(code_out), 64'h000080);
      check("single_hold_valid", 64'(valid), 64'h04);
      check("single_hold_frame", 64'(fd_count), 64'd0);
      idle();

      // glitch: short 0x4f run must not commit, 0x66 does
      hold(8'h01, 7'h4f, 3);
      hold(8'h01, 7'h66, 4);
      check("glitch_precommit", 64'(code_out), 64'h000080);
      idle();
      check("glitch_code", 64'(code_out), 64'h000084);
      check("glitch_valid", 64'(valid), 64'h05);
      hold(8'h03, 7'h3f, 10);
      idle();
      check("multi_sel_code", 64'(code_out), 64'h000084);
      check("multi_sel_valid", 64'(valid), 64'h05);
      check("multi_sel_err", 64'(err), 64'h0);

      // unrecognised pattern keeps code/valid, sets err
      hold(8'h02, 7'h7d, 4);
      idle();
      check("inv_first_code", 64'(code_out), 64'h0000b4);
      hold(8'h02, 7'h00, 4);
      idle();
      check("inv_err", 64'(err), 64'h02);
      check("inv_valid", 64'(valid), 64'h07);
      check("inv_code", 64'(code_out), 64'h0000b4);
      hold(8'h02, 7'h06, 4);
      idle();
      check("inv_fix_err", 64'(err), 64'h00);
      check("inv_fix_code", 64'(code_out), 64'h00008c);

      // full frame, digit i gets code 7-i
      for (int i = 0; i < 8; i++) hold(8'(1 << i), pat[7-i], 4);
      idle();
      check("frame1_code", 64'(code_out), 64'h053977);
      check("frame1_valid", 64'(valid), 64'hff);
      check("frame1_commit_edge", 64'(frame_done), 64'h0);
      tick();
      check("frame1_pulse", 64'(frame_done), 64'h1);
      tick();
      check("frame1_pulse_end", 64'(frame_done), 64'h0);
      check("frame1_count", 64'(fd_count), 64'd1);

      // second scan, digit i gets code i
      for (int i = 0; i < 8; i++) hold(8'(1 << i), pat[i], 4);
      idle();
      tick(); tick();
      check("frame2_code", 64'(code_out), 64'hfac688);
      check("frame2_no_refire", 64'(fd_count), 64'd1);

      // clr on the commit edge of digit 5
      hold(8'h20, 7'h4f, 4);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_code", 64'(code_out), 64'h0);
      check("clr_valid", 64'(valid), 64'h0);
      check("clr_err", 64'(err), 64'h0);
      check("clr_frame", 64'(frame_done), 64'h0);
      hold(8'h20, 7'h4f, 4);
      check("clr_rehold_pending", 64'(valid), 64'h0);
      hold(8'h20, 7'h4f, 1);
      check("clr_rehold_valid", 64'(valid), 64'h20);
      check("clr_rehold_code", 64'(code_out), 64'h018000);
      idle();

      // rst mid-run restarts the stability count
      hold(8'h01, 7'h06, 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_valid", 64'(valid), 64'h0);
      hold(8'h01, 7'h06, 4);
      check("rst_mid_pending", 64'(valid), 64'h0);
      hold(8'h01, 7'h06, 1);
      check("rst_mid_valid2", 64'(valid), 64'h01);
      check("rst_mid_code", 64'(code_out), 64'h000001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
